// File: rtl/timer_pkg.sv
// Shared state codes, BCD limits and BCD arithmetic helpers for the countdown timer.
`default_nettype none

package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_NINE     = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] BLANK_ALL    = 4'b1111;

    // Two-digit BCD increment, 99 wraps to 00.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v[3:0] == BCD_NINE) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == BCD_NINE) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    // MM:SS BCD decrement by one second; caller guarantees the value is not 00:00.
    function automatic logic [15:0] bcd_time_dec(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd0) begin
            r[3:0] = t[3:0] - 4'd1;
        end else begin
            r[3:0] = BCD_NINE;
            if (t[7:4] != 4'd0) begin
                r[7:4] = t[7:4] - 4'd1;
            end else begin
                r[7:4] = SEC_TENS_MAX;
                if (t[11:8] != 4'd0) begin
                    r[11:8] = t[11:8] - 4'd1;
                end else begin
                    r[11:8]  = BCD_NINE;
                    r[15:12] = t[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV enabled cycles.
`default_nettype none

module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/segment_timer_ctrl.sv
// MM:SS countdown controller: button conditioning, set/run/pause/done FSM, BCD digit outputs.
`default_nettype none

module segment_timer_ctrl
    import timer_pkg::*;
#(
    parameter int         TICK_DIV   = 50_000_000,
    parameter logic [7:0] PRESET_MIN = 8'h05
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_btn,
    input  logic        clear_btn,
    input  logic        inc_btn,
    output logic [15:0] bcd_out,
    output logic [3:0]  blank,
    output logic        running,
    output logic        alarm
);

    // Button vectors are ordered {clear, start, inc}.
    logic [2:0] sync_a, sync_b, hist, pulse;
    logic       clear_p, start_p, inc_p;

    state_t      state, state_n;
    logic [7:0]  set_min, set_min_n;
    logic [15:0] tval, tval_n, tval_dec;
    logic [3:0]  blank_r, blank_n;
    logic        tick, presc_en, presc_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
            hist   <= '0;
        end else begin
            sync_a <= {clear_btn, start_btn, inc_btn};
            sync_b <= sync_a;
            hist   <= sync_b;
        end
    end

    assign pulse   = sync_b & ~hist;
    assign clear_p = pulse[2];
    assign start_p = pulse[1];
    assign inc_p   = pulse[0];

    assign tval_dec = bcd_time_dec(tval);

    always_comb begin
        state_n   = state;
        set_min_n = set_min;
        tval_n    = tval;
        blank_n   = blank_r;
        unique case (state)
            ST_IDLE: begin
                // Start wins over inc and uses the pre-increment minutes.
                if (start_p && (set_min != 8'h00)) begin
                    state_n = ST_RUN;
                end else if (inc_p) begin
                    set_min_n = bcd2_inc(set_min);
                    tval_n    = {set_min_n, 8'h00};
                end
            end
            ST_RUN: begin
                if (tick) begin
                    tval_n = tval_dec;
                    if (tval_dec == 16'h0000) begin
                        state_n = ST_DONE;
                    end else if (start_p) begin
                        state_n = ST_PAUSE;
                    end
                end else if (start_p) begin
                    state_n = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (start_p) begin
                    state_n = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start_p) begin
                    state_n = ST_IDLE;
                    tval_n  = {set_min, 8'h00};
                    blank_n = 4'b0000;
                end else if (tick) begin
                    blank_n = blank_r ^ BLANK_ALL;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (clear_p) begin
            state_n   = ST_IDLE;
            set_min_n = set_min;
            tval_n    = {set_min, 8'h00};
            blank_n   = 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            set_min <= PRESET_MIN;
            tval    <= {PRESET_MIN, 8'h00};
            blank_r <= 4'b0000;
        end else begin
            state   <= state_n;
            set_min <= set_min_n;
            tval    <= tval_n;
            blank_r <= blank_n;
        end
    end

    // Prescaler restarts on any entry to IDLE/DONE and on a fresh start; PAUSE->RUN resumes.
    assign presc_en  = (state == ST_RUN) || (state == ST_DONE);
    assign presc_clr = (state_n != state) &&
                       ((state_n == ST_IDLE) || (state_n == ST_DONE) || (state == ST_IDLE));

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (presc_en),
        .clr   (presc_clr),
        .tick  (tick)
    );

    assign bcd_out = tval;
    assign blank   = blank_r;
    assign running = (state == ST_RUN);
    assign alarm   = (state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_segment_timer_ctrl.sv
// Randomized and directed bench for segment_timer_ctrl against a seconds-based reference model.
`default_nettype none

module tb_segment_timer_ctrl;

    localparam int DIV = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_btn = 1'b0, clear_btn = 1'b0, inc_btn = 1'b0;
    logic [15:0] bcd_out;
    logic [3:0]  blank;
    logic        running, alarm;

    int checks = 0;
    int failures = 0;

    // Reference model: remaining time in whole seconds, set minutes as a decimal integer.
    int m_st, m_setm, m_secs, m_cnt, m_blnk;
    logic [2:0] a1, a2, a3;

    segment_timer_ctrl #(
        .TICK_DIV   (DIV),
        .PRESET_MIN (8'h05)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_btn (start_btn),
        .clear_btn (clear_btn),
        .inc_btn   (inc_btn),
        .bcd_out   (bcd_out),
        .blank     (blank),
        .running   (running),
        .alarm     (alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int secs);
        int mm, ss;
        mm = secs / 60;
        ss = secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_setm = 5; m_secs = 300; m_cnt = 0; m_blnk = 0;
        a1 = '0; a2 = '0; a3 = '0;
    endtask

    task automatic model_step();
        logic [2:0] p;
        int  old;
        logic tk;
        p   = a2 & ~a3;
        tk  = ((m_st == M_RUN) || (m_st == M_DONE)) && (m_cnt == DIV - 1);
        old = m_st;
        if (p[2]) begin
            m_st = M_IDLE; m_secs = m_setm * 60; m_blnk = 0;
        end else begin
            case (m_st)
                M_IDLE: begin
                    if (p[1] && m_setm != 0) m_st = M_RUN;
                    else if (p[0]) begin
                        m_setm = (m_setm + 1) % 100;
                        m_secs = m_setm * 60;
                    end
                end
                M_RUN: begin
                    if (tk) m_secs = m_secs - 1;
                    if (tk && m_secs == 0) m_st = M_DONE;
                    else if (p[1]) m_st = M_PAUSE;
                end
                M_PAUSE: if (p[1]) m_st = M_RUN;
                default: begin
                    if (p[1]) begin
                        m_st = M_IDLE; m_secs = m_setm * 60; m_blnk = 0;
                    end else if (tk) m_blnk = 1 - m_blnk;
                end
            endcase
        end
        if (m_st != old && (m_st == M_IDLE || m_st == M_DONE || old == M_IDLE)) m_cnt = 0;
        else if (old == M_RUN || old == M_DONE) m_cnt = (m_cnt + 1) % DIV;
        a3 = a2; a2 = a1; a1 = {clear_btn, start_btn, inc_btn};
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("model_bcd", bcd_out, to_bcd(m_secs));
                chk("model_flags", {10'd0, blank, running, alarm},
                    {10'd0, (m_blnk != 0) ? 4'hF : 4'h0, m_st == M_RUN, m_st == M_DONE});
            end
        end
    end

    task automatic set_btns(input logic [2:0] m);
        {clear_btn, start_btn, inc_btn} = m;
    endtask

    task automatic press_now(input logic [2:0] m, input int hold);
        #1 set_btns(m);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        #1 set_btns(3'b000);
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press(input logic [2:0] m);
        @(negedge clk);
        press_now(m, 4);
    endtask

    task automatic flags(input string nm, input logic [3:0] b, input logic r, input logic a);
        chk(nm, {10'd0, blank, running, alarm}, {10'd0, b, r, a});
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_bcd", bcd_out, 16'h0500);
        flags("reset_flags", 4'h0, 1'b0, 1'b0);

        repeat (3) press(3'b001);
        chk("inc3", bcd_out, 16'h0800);
        repeat (91) press(3'b001);
        chk("inc_to_99", bcd_out, 16'h9900);
        press(3'b001);
        chk("inc_wrap", bcd_out, 16'h0000);
        press(3'b010);
        chk("start_at_zero_bcd", bcd_out, 16'h0000);
        flags("start_at_zero_idle", 4'h0, 1'b0, 1'b0);

        press(3'b001);
        press(3'b010);
        n = 0;
        while (bcd_out == 16'h0100 && n < 20) begin @(negedge clk); n++; end
        chk("first_tick", bcd_out, 16'h0059);
        n = 0;
        while (!alarm && n < 400) begin @(negedge clk); n++; end
        chk("done_bcd", bcd_out, 16'h0000);
        flags("done_entry", 4'h0, 1'b0, 1'b1);
        n = 0;
        while (blank == 4'h0 && n < 10) begin @(negedge clk); n++; end
        flags("done_blank1", 4'hF, 1'b0, 1'b1);
        n = 0;
        while (blank == 4'hF && n < 10) begin @(negedge clk); n++; end
        flags("done_blank0", 4'h0, 1'b0, 1'b1);
        press(3'b100);
        chk("clear_from_done", bcd_out, 16'h0100);

        press(3'b001);
        press(3'b010);
        n = 0;
        while (bcd_out != 16'h0157 && n < 100) begin @(negedge clk); n++; end
        press_now(3'b010, 4);
        repeat (100) @(negedge clk);
        chk("pause_hold", bcd_out, 16'h0157);
        flags("pause_flags", 4'h0, 1'b0, 1'b0);
        press(3'b010);
        n = 0;
        while (bcd_out == 16'h0157 && n < 20) begin @(negedge clk); n++; end
        chk("resume_dec", bcd_out, 16'h0156);

        press(3'b110);
        chk("start_clear_bcd", bcd_out, 16'h0200);
        flags("start_clear_idle", 4'h0, 1'b0, 1'b0);

        @(negedge clk);
        #1 set_btns(3'b011);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("start_inc_bcd", bcd_out, 16'h0200);
        flags("start_inc_run", 4'h0, 1'b1, 1'b0);
        #1 set_btns(3'b000);
        repeat (10) @(negedge clk);

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_bcd", bcd_out, 16'h0500);
        flags("async_rst_flags", 4'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_bcd", bcd_out, 16'h0500);
        flags("post_rst_idle", 4'h0, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            int r;
            logic [2:0] m;
            r = $urandom_range(0, 99);
            if (r < 40)      m = 3'b010;
            else if (r < 62) m = 3'b001;
            else if (r < 70) m = 3'b100;
            else if (r < 78) m = 3'b011;
            else if (r < 84) m = 3'b110;
            else if (r < 88) m = 3'b111;
            else             m = 3'b000;
            @(negedge clk);
            press_now(m, $urandom_range(1, 5));
            repeat (($urandom_range(0, 19) == 0) ? 300 : $urandom_range(0, 30)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
